// File: rtl/coin_pkg.sv
// Shared constants and helpers for the coin input conditioner.
// Optional macro COIN_INPUT_CONDITIONER_COUNT_EN enables the per-channel pulse counters.
package coin_pkg;

    localparam int CH_X                    = 0;
    localparam int CH_Y                    = 1;
    localparam int NUM_CH                  = 2;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int COIN_CNT_W              = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COIN_CNT_W-1:0] sat_inc(input logic [COIN_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: synchroniser chain followed by a stable-level debouncer.
// rise strobes on the edge where the debounced level is accepted as 0->1.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync;
    logic                   stable_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   accept;

    assign sync   = sync_reg[SYNC_STAGES-1];
    // A new level is taken once it has differed from stable for DEBOUNCE_CYCLES edges in a row.
    assign accept = (sync != stable_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept && sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (sync == stable_reg) begin
            cnt_reg <= '0;
        end else if (accept) begin
            stable_reg <= sync;
            cnt_reg    <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// Conditions two raw coin switches into single-cycle, mutually exclusive coin pulses.
// Define COIN_INPUT_CONDITIONER_COUNT_EN to add saturating per-channel pulse counters.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coin_x_raw,
    input  logic                  coin_y_raw,
    input  logic                  inhibit,
    output logic                  coin_x_pulse,
    output logic                  coin_y_pulse,
`ifdef COIN_INPUT_CONDITIONER_COUNT_EN
    output logic                  overrun,
    output logic [COIN_CNT_W-1:0] coin_x_count,
    output logic [COIN_CNT_W-1:0] coin_y_count
`else
    output logic                  overrun
`endif
);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] issue;
    logic [NUM_CH-1:0] lost;
    logic [NUM_CH-1:0] pending_reg;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] pulse_reg;
    logic              overrun_reg;
    logic              overrun_next;

    assign raw_vec = {coin_y_raw, coin_x_raw};

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        coin_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_vec[gi]),
            .rise (rise[gi])
        );
    end

    // X wins a tie; a pending flag freed this edge can accept a new press without loss.
    always_comb begin
        issue = '0;
        if (!inhibit) begin
            if (pending_reg[CH_X]) begin
                issue[CH_X] = 1'b1;
            end else if (pending_reg[CH_Y]) begin
                issue[CH_Y] = 1'b1;
            end
        end
        lost         = rise & pending_reg & ~issue;
        pending_next = rise | (pending_reg & ~issue);
        overrun_next = overrun_reg | (|lost);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            pulse_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            pulse_reg   <= issue;
            overrun_reg <= overrun_next;
        end
    end

    assign coin_x_pulse = pulse_reg[CH_X];
    assign coin_y_pulse = pulse_reg[CH_Y];
    assign overrun      = overrun_reg;

`ifdef COIN_INPUT_CONDITIONER_COUNT_EN
    logic [COIN_CNT_W-1:0] count_reg [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (issue[i]) begin
                    count_reg[i] <= sat_inc(count_reg[i]);
                end
            end
        end
    end

    assign coin_x_count = count_reg[CH_X];
    assign coin_y_count = count_reg[CH_Y];
`endif

endmodule
